// File: rtl/matrix_ops_pkg.sv
// Shared definitions for the matrix_ops library: FSM encoding, clog2 and
// the result-narrowing (saturate or truncate) helper.
package matrix_ops_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // val must already be sign- or zero-extended to 64 bits; the caller keeps
  // the low rw bits of the returned value.
  function automatic logic [63:0] convert_result(input logic signed [63:0] val,
                                                 input int rw,
                                                 input logic is_signed,
                                                 input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (is_signed) begin
      hi = (64'sd1 <<< (rw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (rw - 1));
    end else begin
      hi = (64'sd1 <<< rw) - 64'sd1;
      lo = '0;
    end
    if (!sat)     return val;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Operand/result bundle for matrix_mult_seq; the master side drives operands
// and the start request, the slave side (the multiplier) returns the result.
interface matrix_mult_seq_if #(
  parameter int FIRST_MATRIX_HEIGHT = 4,
  parameter int BOTH_MATRIX_W_H     = 4,
  parameter int SECOND_MATRIX_WIDTH = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int RESULT_WIDTH        = 16
);
  logic i_calc;
  logic i_signed;
  logic i_saturate;
  logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0]     i_matrix_1;
  logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0]     i_matrix_2;
  logic [FIRST_MATRIX_HEIGHT*SECOND_MATRIX_WIDTH*RESULT_WIDTH-1:0] o_result;
  logic o_busy;
  logic o_ready;

  modport master (output i_calc, i_signed, i_saturate, i_matrix_1, i_matrix_2,
                  input  o_result, o_busy, o_ready);
  modport slave  (input  i_calc, i_signed, i_saturate, i_matrix_1, i_matrix_2,
                  output o_result, o_busy, o_ready);
endinterface

// File: rtl/matrix_mac.sv
// Single multiply-accumulate lane; sum is acc+product so the final term of an
// element can be stored in the same edge that clears the accumulator.
module matrix_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  sum
);
  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] prod;

  // Low ACC_WIDTH bits of the product are identical for signed and unsigned.
  assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){sgn & b[DATA_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc_reg + prod;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)    acc_reg <= '0;
    else if (clr) acc_reg <= '0;
    else if (en)  acc_reg <= sum;
  end
endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential C = A x B using one shared MAC per clock; operands and modes are
// latched at start so the caller may change them while the run is busy.
module matrix_mult_seq
  import matrix_ops_pkg::*;
#(
  parameter int FIRST_MATRIX_HEIGHT = 4,
  parameter int BOTH_MATRIX_W_H     = 4,
  parameter int SECOND_MATRIX_WIDTH = 4,
  parameter int DATA_WIDTH          = 8,
  parameter int RESULT_WIDTH        = 16
) (
  input logic          clk,
  input logic          i_rst,
  matrix_mult_seq_if.slave io
);
  localparam int M  = FIRST_MATRIX_HEIGHT;
  localparam int K  = BOTH_MATRIX_W_H;
  localparam int N  = SECOND_MATRIX_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int RW = RESULT_WIDTH;
  localparam int ACC_WIDTH = 2*DATA_WIDTH + clog2(K) + 1;
  localparam int IW = (M > 1) ? clog2(M) : 1;
  localparam int KW = (K > 1) ? clog2(K) : 1;
  localparam int JW = (N > 1) ? clog2(N) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  if (M < 1 || K < 1 || N < 1) begin : g_bad_dims
    $error("matrix_mult_seq: every matrix dimension must be at least 1");
  end
  if (ACC_WIDTH > 63 || RW > 62) begin : g_bad_width
    $error("matrix_mult_seq: accumulator or result width too large");
  end

  state_t state_reg, state_next;
  logic [IW-1:0] i_reg;
  logic [KW-1:0] k_reg;
  logic [JW-1:0] j_reg;
  logic [M*K*DW-1:0] a_reg;
  logic [K*N*DW-1:0] b_reg;
  logic sgn_reg, sat_reg, ready_reg;
  logic [RW-1:0] buf_reg [M][N];
  logic [M*N*RW-1:0] result_reg;

  logic [DW-1:0] a_elems [M][K];
  logic [DW-1:0] b_elems [K][N];
  logic start, mac_clr, mac_en, last_term;
  logic [ACC_WIDTH-1:0] sum;
  logic signed [63:0] acc64;

  for (genvar gi = 0; gi < K; gi++) begin : g_k
    for (genvar gr = 0; gr < M; gr++) begin : g_a
      assign a_elems[gr][gi] = a_reg[(gr*K+gi)*DW +: DW];
    end
    for (genvar gc = 0; gc < N; gc++) begin : g_b
      assign b_elems[gi][gc] = b_reg[(gi*N+gc)*DW +: DW];
    end
  end

  matrix_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk   (clk),
    .i_rst (i_rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .sgn   (sgn_reg),
    .a     (a_elems[i_reg][k_reg]),
    .b     (b_elems[k_reg][j_reg]),
    .sum   (sum)
  );

  assign acc64 = sgn_reg ? {{(64-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum}
                         : {{(64-ACC_WIDTH){1'b0}}, sum};

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    last_term  = 1'b0;
    case (state_reg)
      IDLE: if (io.i_calc) begin
        start      = 1'b1;
        mac_clr    = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        mac_en = 1'b1;
        if (k_reg == K_LAST) begin
          last_term = 1'b1;
          mac_clr   = 1'b1;
          if (i_reg == I_LAST && j_reg == J_LAST) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sgn_reg    <= 1'b0;
      sat_reg    <= 1'b0;
      ready_reg  <= 1'b0;
      result_reg <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          buf_reg[r][c] <= '0;
    end else begin
      ready_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++)
            result_reg[(r*N+c)*RW +: RW] <= buf_reg[r][c];
      end
      if (start) begin
        a_reg   <= io.i_matrix_1;
        b_reg   <= io.i_matrix_2;
        sgn_reg <= io.i_signed;
        sat_reg <= io.i_saturate;
        i_reg   <= '0;
        j_reg   <= '0;
        k_reg   <= '0;
      end else if (state_reg == CALC) begin
        if (last_term) begin
          buf_reg[i_reg][j_reg] <= RW'(convert_result(acc64, RW, sgn_reg, sat_reg));
          k_reg <= '0;
          if (j_reg == J_LAST) begin
            j_reg <= '0;
            i_reg <= (i_reg == I_LAST) ? '0 : i_reg + 1'b1;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end else begin
          k_reg <= k_reg + 1'b1;
        end
      end
    end
  end

  assign io.o_busy   = (state_reg == CALC) || (state_reg == DONE);
  assign io.o_ready  = ready_reg;
  assign io.o_result = result_reg;
endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed bench for matrix_mult_seq: a 4x4x4 instance for the main vectors
// and a 2x3x4 instance for the non-square case.
module tb_matrix_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  matrix_mult_seq_if #(.FIRST_MATRIX_HEIGHT(4), .BOTH_MATRIX_W_H(4),
                       .SECOND_MATRIX_WIDTH(4), .DATA_WIDTH(8), .RESULT_WIDTH(16)) io();
  matrix_mult_seq_if #(.FIRST_MATRIX_HEIGHT(2), .BOTH_MATRIX_W_H(3),
                       .SECOND_MATRIX_WIDTH(4), .DATA_WIDTH(8), .RESULT_WIDTH(16)) io2();

  matrix_mult_seq #(.FIRST_MATRIX_HEIGHT(4), .BOTH_MATRIX_W_H(4),
                    .SECOND_MATRIX_WIDTH(4), .DATA_WIDTH(8), .RESULT_WIDTH(16))
    dut (.clk(clk), .i_rst(rst), .io(io));
  matrix_mult_seq #(.FIRST_MATRIX_HEIGHT(2), .BOTH_MATRIX_W_H(3),
                    .SECOND_MATRIX_WIDTH(4), .DATA_WIDTH(8), .RESULT_WIDTH(16))
    dut2 (.clk(clk), .i_rst(rst), .io(io2));

  typedef struct {
    logic        sgn;
    logic        sat;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] ev;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_calc(input logic sgn, input logic sat, input logic [127:0] a,
                          input logic [127:0] b, output int lat, output int busy_cnt);
    @(negedge clk);
    io.i_signed   = sgn;
    io.i_saturate = sat;
    io.i_matrix_1 = a;
    io.i_matrix_2 = b;
    io.i_calc     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.i_calc = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!io.o_ready && lat < 200) begin
      if (io.o_busy) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] a, b;
    logic [255:0] exp;
    logic [127:0] a2;
    logic [127:0] exp2;
    int lat, busy_cnt, rdy_cnt;

    io.i_calc = 0; io.i_signed = 0; io.i_saturate = 0; io.i_matrix_1 = '0; io.i_matrix_2 = '0;
    io2.i_calc = 0; io2.i_signed = 0; io2.i_saturate = 0; io2.i_matrix_1 = '0; io2.i_matrix_2 = '0;

    vecs[0] = '{sgn: 1'b1, sat: 1'b0, av: 8'hFF, bv: 8'h02, ev: 16'hFFF8};
    vecs[1] = '{sgn: 1'b0, sat: 1'b1, av: 8'hFF, bv: 8'hFF, ev: 16'hFFFF};
    vecs[2] = '{sgn: 1'b0, sat: 1'b0, av: 8'hFF, bv: 8'hFF, ev: 16'hF804};
    vecs[3] = '{sgn: 1'b1, sat: 1'b1, av: 8'h80, bv: 8'h80, ev: 16'h7FFF};
    vecs[4] = '{sgn: 1'b1, sat: 1'b1, av: 8'h80, bv: 8'h7F, ev: 16'h8000};
    vecs[5] = '{sgn: 1'b1, sat: 1'b0, av: 8'h80, bv: 8'h80, ev: 16'h0000};
    vecs[6] = '{sgn: 1'b0, sat: 1'b1, av: 8'h10, bv: 8'h10, ev: 16'h0400};

    #3;
    check("reset_busy",    256'(io.o_busy),   256'(0));
    check("reset_ready",   256'(io.o_ready),  256'(0));
    check("reset_result",  io.o_result,       256'(0));
    check("reset_result2", {128'd0, io2.o_result}, 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Identity times 1..16 returns B; also latency, busy length and pulse width.
    a = '0; b = '0; exp = '0;
    for (int r = 0; r < 4; r++) begin
      a[(r*4+r)*8 +: 8] = 8'd1;
      for (int c = 0; c < 4; c++) begin
        b[(r*4+c)*8 +: 8]    = 8'(r*4 + c + 1);
        exp[(r*4+c)*16 +: 16] = 16'(r*4 + c + 1);
      end
    end
    run_calc(1'b0, 1'b0, a, b, lat, busy_cnt);
    $display("identity: lat=%0d busy=%0d result=%h", lat, busy_cnt, io.o_result);
    check("identity_result", io.o_result, exp);
    check("identity_latency", 256'(lat), 256'(65));
    check("identity_busy_cycles", 256'(busy_cnt), 256'(65));
    @(negedge clk);
    check("ready_one_cycle", 256'(io.o_ready), 256'(0));
    check("result_holds", io.o_result, exp);

    for (int v = 0; v < 7; v++) begin
      run_calc(vecs[v].sgn, vecs[v].sat, {16{vecs[v].av}}, {16{vecs[v].bv}}, lat, busy_cnt);
      $display("vec %0d: sgn=%0b sat=%0b a=%h b=%h lat=%0d elem0=%h", v, vecs[v].sgn,
               vecs[v].sat, vecs[v].av, vecs[v].bv, lat, io.o_result[15:0]);
      check($sformatf("vec%0d_result", v), io.o_result, {16{vecs[v].ev}});
      check($sformatf("vec%0d_latency", v), 256'(lat), 256'(65));
    end

    // Start request and operand changes during a run must not disturb it.
    @(negedge clk);
    io.i_signed = 0; io.i_saturate = 0;
    io.i_matrix_1 = {16{8'h01}}; io.i_matrix_2 = {16{8'h02}};
    io.i_calc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.i_calc = 1'b0;
    rdy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (io.o_ready) rdy_cnt++;
      if (c == 10) io.i_calc = 1'b1;
      if (c == 11) io.i_calc = 1'b0;
      if (c == 20) begin
        io.i_signed = 1; io.i_saturate = 1;
        io.i_matrix_1 = {16{8'h03}}; io.i_matrix_2 = {16{8'h03}};
      end
    end
    $display("busy_ignore: ready_pulses=%0d result=%h", rdy_cnt, io.o_result);
    check("busy_ignore_pulses", 256'(rdy_cnt), 256'(1));
    check("busy_ignore_result", io.o_result, {16{16'h0008}});
    run_calc(1'b1, 1'b1, {16{8'h03}}, {16{8'h03}}, lat, busy_cnt);
    $display("after_ignore: lat=%0d result=%h", lat, io.o_result);
    check("new_operands_result", io.o_result, {16{16'h0024}});

    // Reset in the middle of a run.
    @(negedge clk);
    io.i_signed = 0; io.i_saturate = 0;
    io.i_matrix_1 = {16{8'h01}}; io.i_matrix_2 = {16{8'h01}};
    io.i_calc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.i_calc = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    $display("mid_reset: busy=%0b ready=%0b result=%h", io.o_busy, io.o_ready, io.o_result);
    check("midreset_busy",   256'(io.o_busy),  256'(0));
    check("midreset_ready",  256'(io.o_ready), 256'(0));
    check("midreset_result", io.o_result,      256'(0));
    @(negedge clk);
    rst = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (io.o_ready || io.o_busy) rdy_cnt++;
    end
    check("midreset_no_ready", 256'(rdy_cnt), 256'(0));

    // Non-square 2x3 by 3x4 on the second instance.
    a2 = '0; exp2 = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) a2[(r*3+c)*8 +: 8] = 8'(r*3 + c + 1);
      for (int c = 0; c < 4; c++) exp2[(r*4+c)*16 +: 16] = (r == 0) ? 16'd6 : 16'd15;
    end
    @(negedge clk);
    io2.i_signed = 0; io2.i_saturate = 0;
    io2.i_matrix_1 = a2[47:0]; io2.i_matrix_2 = {12{8'h01}};
    io2.i_calc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io2.i_calc = 1'b0;
    lat = 0;
    while (!io2.o_ready && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("small: lat=%0d result=%h", lat, io2.o_result);
    check("small_result",  {128'd0, io2.o_result}, {128'd0, exp2});
    check("small_latency", 256'(lat), 256'(25));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
- Sequential, parametrised matrix multiplier C = A x B for the matrix_ops library.
- A is FIRST_MATRIX_HEIGHT x BOTH_MATRIX_W_H; B is BOTH_MATRIX_W_H x SECOND_MATRIX_WIDTH.
- Uses one shared multiply-accumulate datapath, one MAC per clock, to trade latency for area.
- Adds signed/unsigned mode, a separate result width with optional saturation, operand latching, and a busy/done handshake.

Parameters:
- FIRST_MATRIX_HEIGHT, 4, rows of A and C (M).
- BOTH_MATRIX_W_H, 4, columns of A and rows of B (K).
- SECOND_MATRIX_WIDTH, 4, columns of B and C (N).
- DATA_WIDTH, 8, operand element width.
- RESULT_WIDTH, 16, result element width.
- Derived localparam ACC_WIDTH = 2*DATA_WIDTH + clog2(K) + 1, the accumulator width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_calc  in  1  start request; sampled only in IDLE.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- i_saturate  in  1  1 = clamp result to RESULT_WIDTH range, 0 = truncate to low bits.
- i_matrix_1  in  M*K*DATA_WIDTH  A; element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
- i_matrix_2  in  K*N*DATA_WIDTH  B; element (r,c) at [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- o_result  out  M*N*RESULT_WIDTH  C; element (r,c) at [(r*N+c)*RESULT_WIDTH +: RESULT_WIDTH].
- o_busy  out  1  high while computing.
- o_ready  out  1  one-cycle done pulse; o_result is valid from this cycle on.

Behaviour:
- Reset (asynchronous, effective immediately) clears all state:
  - State returns to IDLE; o_busy=0, o_ready=0, o_result=0.
  - Accumulator, indices, internal result buffer and latched operands/modes are cleared.
  - A reset mid-operation aborts the computation with no o_ready pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - On edge E0 with i_calc=1, latch i_matrix_1, i_matrix_2, i_signed and i_saturate.
  - Set indices i=j=k=0, clear the accumulator, set o_busy=1, go to CALC.
  - o_ready=0 in every IDLE cycle except the single pulse cycle described under DONE.
- CALC, one MAC per edge E1..E(M*N*K):
  - acc <= acc + ext(A[i][k]) * ext(B[k][j]).
  - ext is sign- or zero-extension to ACC_WIDTH according to the latched mode.
  - k advances fastest, then j, then i.
- Last term of an element (k==K-1):
  - Final sum (acc + product) is converted and written to internal buffer slot i*N+j.
  - Accumulator is cleared in the same edge; no bubble between elements.
- Conversion:
  - Saturate, unsigned: clamp to [0, 2^RESULT_WIDTH-1].
  - Saturate, signed: clamp to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
  - Truncate: take the low RESULT_WIDTH bits.
- At edge E(M*N*K): the last element is written and the state goes to DONE.
- DONE, one cycle:
  - At the next edge E(M*N*K+1), copy the buffer to o_result, set o_ready=1, o_busy=0, go to IDLE.
  - o_ready falls at E(M*N*K+2).
  - Total latency from the i_calc sampling edge to o_ready rising is M*N*K+1 edges.
- o_result changes only on the edge that raises o_ready and holds until the next completion or reset.
- i_calc while busy (CALC or DONE) is ignored; no queuing.
- Input operand and mode changes while busy have no effect on the current result.
- i_calc high in the o_ready cycle (state IDLE) starts a new computation; back-to-back runs are legal.
- Degenerate sizes with any dimension < 1 are illegal; elaboration must fail.

Decomposition:
- Package matrix_ops_pkg holds:
  - State encoding constants IDLE/CALC/DONE.
  - A clog2 function.
  - A saturate/truncate function parameterised by signed mode.
- One sub-module, matrix_mac:
  - Takes DATA_WIDTH operands, signed flag, clear and enable inputs.
  - Holds the ACC_WIDTH accumulator register and outputs acc+product combinationally for the final-term write.
- The top level holds the FSM, the index counters, operand/mode latches, the result buffer and the output register.

Test Plan:
- Defaults, unsigned, A = identity, B elements 1..16 -> o_result = B; o_ready is one cycle wide, 65 edges after the i_calc edge; o_busy high for exactly 65 cycles.
- Signed, saturate=0, A all 0xFF (-1), B all 0x02 -> every result 0xFFF8 (-8).
- Unsigned, A and B all 0xFF: saturate=1 -> every result 0xFFFF; saturate=0 -> every result 0xF804 (260100 mod 65536).
- Signed, saturate=1, A and B all 0x80 (-128) -> sum 65536 -> every result 0x7FFF. Same with B all 0x7F -> sum -65024 -> every result 0x8000.
- Start a run, then pulse i_calc again at cycle 10 and change all operands at cycle 20 -> one o_ready only; result matches the operands latched at start; the next i_calc after o_ready uses the new operands.
- Assert i_rst at cycle 30 of a run -> o_busy, o_ready and o_result are 0 immediately with no o_ready pulse. After release, with parameters M=2, K=3, N=4, A rows (1,2,3)/(4,5,6) and B all 1 -> rows (6,6,6,6)/(15,15,15,15), latency 25 edges.
